exmem_mem_access: RTL and testbench

- Consumer-side end of the EX/MEM pipeline interface: the MEM-stage access unit.
- Takes the registered memory controls and data (MemRead, MemWrite, ByteSel, ALU result as address, store data) and runs a req/ack transaction on the data-memory bus.
- Aligns store lanes and extracts/extends load data.
- Stalls the pipeline so the EX/MEM contents stay frozen until the access completes.

---
 rtl/exmem_mem_access.sv | 147 ++++++++++++++
 tb/tb_exmem_mem_access.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/exmem_mem_access.sv
// exmem_mem_access: MEM-stage data-memory access unit with req/ack bus, lane alignment and pipeline stall
module exmem_mem_access #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        MemRead_In,
  input  logic        MemWrite_In,
  input  logic [1:0]  ByteSel_In,
  input  logic [31:0] Address_In,
  input  logic [31:0] WriteData_In,
  output logic        Stall_Out,
  output logic [31:0] ReadData_Out,
  output logic        Done_Out,
  output logic        Misaligned_Out,
  output logic        BusError_Out,
  output logic        MemReq_Out,
  output logic        MemWe_Out,
  output logic [31:0] MemAddr_Out,
  output logic [31:0] MemWData_Out,
  output logic [3:0]  MemBE_Out,
  input  logic        MemAck_In,
  input  logic [31:0] MemRData_In
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        req_q, req_d, we_q, we_d, done_q, done_d, mis_q, mis_d, berr_q, berr_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  sel_q, sel_d, lane_q, lane_d;
  logic        req, aligned;
  logic [31:0] wdata_lane, rshift, rdata_ext;
  logic [3:0]  be_lane;
  logic [15:0] rhalf;
  logic [7:0]  rbyte;
  assign req        = MemRead_In | MemWrite_In;
  assign aligned    = ByteSel_In == 2'b00 ? Address_In[1:0] == 2'b00 :
                      ByteSel_In == 2'b01 ? !Address_In[0] : 1'b1;
  assign wdata_lane = ByteSel_In == 2'b00 ? WriteData_In :
                      ByteSel_In == 2'b01 ? {2{WriteData_In[15:0]}} : {4{WriteData_In[7:0]}};
  assign be_lane    = ByteSel_In == 2'b00 ? 4'b1111 :
                      ByteSel_In == 2'b01 ? (Address_In[1] ? 4'b1100 : 4'b0011) :
                      4'b0001 << Address_In[1:0];
  // Lane and size are captured at issue so extraction does not depend on the stalled inputs
  assign rshift     = MemRData_In >> {lane_q, 3'b000};
  assign rhalf      = rshift[15:0];
  assign rbyte      = rshift[7:0];
  assign rdata_ext  = sel_q == 2'b00 ? MemRData_In :
                      sel_q == 2'b01 ? {{16{rhalf[15]}}, rhalf} :
                      {{24{sel_q == 2'b10 && rbyte[7]}}, rbyte};
  assign Stall_Out      = (state_q == IDLE && req) || state_q == BUSY;
  assign ReadData_Out   = rdata_q;
  assign Done_Out       = done_q;
  assign Misaligned_Out = mis_q;
  assign BusError_Out   = berr_q;
  assign MemReq_Out     = req_q;
  assign MemWe_Out      = we_q;
  assign MemAddr_Out    = addr_q;
  assign MemWData_Out   = wdata_q;
  assign MemBE_Out      = be_q;
  // Next-state: issue from IDLE, wait for ack or timeout in BUSY, single-cycle completion in DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    sel_d   = sel_q;
    lane_d  = lane_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    berr_d  = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        if (aligned) begin
          req_d   = 1'b1;
          we_d    = MemWrite_In;
          addr_d  = {Address_In[31:2], 2'b00};
          wdata_d = wdata_lane;
          be_d    = be_lane;
          sel_d   = ByteSel_In;
          lane_d  = Address_In[1:0];
          cnt_d   = '0;
          state_d = BUSY;
        end else begin
          rdata_d = '0;
          mis_d   = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      BUSY: if (req_q && MemAck_In) begin
        req_d   = 1'b0;
        rdata_d = we_q ? 32'h0 : rdata_ext;
        done_d  = 1'b1;
        state_d = DONE;
      end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        req_d   = 1'b0;
        rdata_d = '0;
        berr_d  = 1'b1;
        done_d  = 1'b1;
        state_d = DONE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State and registered bus/result fields
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      sel_q   <= '0;
      lane_q  <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      sel_q   <= sel_d;
      lane_q  <= lane_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end
endmodule

// File: tb/tb_exmem_mem_access.sv
// tb_exmem_mem_access: scoreboard bench for the MEM-stage access unit
module tb_exmem_mem_access;
  logic        Clock = 1'b0, Reset = 1'b1;
  logic        MemRead_In = 1'b0, MemWrite_In = 1'b0;
  logic [1:0]  ByteSel_In = 2'b00;
  logic [31:0] Address_In = '0, WriteData_In = '0;
  logic        Stall_Out, Done_Out, Misaligned_Out, BusError_Out, MemReq_Out, MemWe_Out;
  logic [31:0] ReadData_Out, MemAddr_Out, MemWData_Out;
  logic [3:0]  MemBE_Out;
  logic        MemAck_In;
  logic [31:0] MemRData_In = '0;
  logic        resp_ack = 1'b0, force_ack = 1'b0;
  int          ack_delay = 0, bcnt = 0;
  int          tests = 0, fails = 0, txn = 0, exp_txn = 0;
  logic        req_prev = 1'b0;
  typedef struct {logic [31:0] rd; logic mis; logic berr;} exp_t;
  exp_t sb[$];
  assign MemAck_In = resp_ack | force_ack;
  exmem_mem_access #(.TIMEOUT(4), .CNT_W(8)) dut (
    .Clock(Clock), .Reset(Reset), .MemRead_In(MemRead_In), .MemWrite_In(MemWrite_In),
    .ByteSel_In(ByteSel_In), .Address_In(Address_In), .WriteData_In(WriteData_In),
    .Stall_Out(Stall_Out), .ReadData_Out(ReadData_Out), .Done_Out(Done_Out),
    .Misaligned_Out(Misaligned_Out), .BusError_Out(BusError_Out), .MemReq_Out(MemReq_Out),
    .MemWe_Out(MemWe_Out), .MemAddr_Out(MemAddr_Out), .MemWData_Out(MemWData_Out),
    .MemBE_Out(MemBE_Out), .MemAck_In(MemAck_In), .MemRData_In(MemRData_In));
  always #5 Clock = ~Clock;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // Bus responder: ack in the ack_delay-th cycle that MemReq is seen high (0 = never)
  always @(negedge Clock) begin
    if (MemReq_Out) begin
      bcnt = bcnt + 1;
      resp_ack = ack_delay > 0 && bcnt == ack_delay;
    end else begin
      bcnt = 0;
      resp_ack = 1'b0;
    end
  end
  // Transaction counter: rising edges of MemReq
  always @(negedge Clock) begin
    if (MemReq_Out && !req_prev) txn = txn + 1;
    req_prev = MemReq_Out;
  end
  // Monitor: every completion is matched against the oldest expected response
  always @(negedge Clock) begin
    if (!Reset && Done_Out) begin
      if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("read_data", ReadData_Out, e.rd);
        chk("misaligned", {31'd0, Misaligned_Out}, {31'd0, e.mis});
        chk("bus_error", {31'd0, BusError_Out}, {31'd0, e.berr});
      end
    end
  end
  task automatic access(input logic rd, input logic wr, input logic [1:0] sel,
                        input logic [31:0] addr, input logic [31:0] wd, input int dly,
                        input logic [31:0] rdat, input int exp_stall, input int exp_reqcyc,
                        input logic exp_we, input logic [31:0] exp_wd, input logic [3:0] exp_be,
                        input logic [31:0] exp_rd, input logic exp_mis, input logic exp_berr);
    int stalls, reqcyc, n;
    exp_t e;
    e.rd = exp_rd; e.mis = exp_mis; e.berr = exp_berr;
    sb.push_back(e);
    if (exp_reqcyc > 0) exp_txn++;
    ack_delay = dly;
    MemRData_In = rdat;
    MemRead_In = rd; MemWrite_In = wr; ByteSel_In = sel; Address_In = addr; WriteData_In = wd;
    stalls = 0; reqcyc = 0; n = 0;
    @(negedge Clock);
    while (!Done_Out && n < 50) begin
      if (Stall_Out) stalls++;
      if (MemReq_Out) begin
        reqcyc++;
        chk("bus_we", {31'd0, MemWe_Out}, {31'd0, exp_we});
        chk("bus_addr", MemAddr_Out, {addr[31:2], 2'b00});
        chk("bus_wdata", MemWData_Out, exp_wd);
        chk("bus_be", {28'd0, MemBE_Out}, {28'd0, exp_be});
      end
      n++;
      @(negedge Clock);
    end
    if (n >= 50) chk("done_timeout", 32'd0, 32'd1);
    chk("stall_cycles", stalls, exp_stall);
    chk("req_cycles", reqcyc, exp_reqcyc);
    chk("stall_in_done", {31'd0, Stall_Out}, 32'd0);
    @(posedge Clock);
    #1;
    MemRead_In = 1'b0; MemWrite_In = 1'b0; ByteSel_In = 2'b00; Address_In = '0; WriteData_In = '0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b0;
    @(negedge Clock);
    chk("rst_req", {31'd0, MemReq_Out}, 32'd0);
    chk("rst_done", {31'd0, Done_Out}, 32'd0);
    chk("rst_stall", {31'd0, Stall_Out}, 32'd0);
    chk("rst_rdata", ReadData_Out, 32'd0);
    chk("rst_addr", MemAddr_Out, 32'd0);
    chk("rst_be", {28'd0, MemBE_Out}, 32'd0);
    @(posedge Clock);
    #1;
    access(1, 0, 2'b00, 32'h100, 32'h0, 3, 32'hDEADBEEF, 4, 3, 0, 32'h0, 4'b1111, 32'hDEADBEEF, 0, 0);
    access(1, 0, 2'b10, 32'h203, 32'h0, 1, 32'h80112233, 2, 1, 0, 32'h0, 4'b1000, 32'hFFFFFF80, 0, 0);
    access(1, 0, 2'b11, 32'h203, 32'h0, 1, 32'h80112233, 2, 1, 0, 32'h0, 4'b1000, 32'h00000080, 0, 0);
    access(1, 0, 2'b01, 32'h202, 32'h0, 2, 32'h80112233, 3, 2, 0, 32'h0, 4'b1100, 32'hFFFF8011, 0, 0);
    access(1, 0, 2'b01, 32'h200, 32'h0, 1, 32'h80112233, 2, 1, 0, 32'h0, 4'b0011, 32'h00002233, 0, 0);
    access(0, 1, 2'b01, 32'h402, 32'h0000ABCD, 1, 32'h0, 2, 1, 1, 32'hABCDABCD, 4'b1100, 32'h0, 0, 0);
    access(1, 0, 2'b00, 32'h101, 32'h0, 1, 32'h0, 1, 0, 0, 32'h0, 4'b0000, 32'h0, 1, 0);
    access(1, 0, 2'b01, 32'h203, 32'h0, 1, 32'h0, 1, 0, 0, 32'h0, 4'b0000, 32'h0, 1, 0);
    access(1, 0, 2'b00, 32'h300, 32'h0, 0, 32'h0, 5, 4, 0, 32'h0, 4'b1111, 32'h0, 0, 1);
    force_ack = 1'b1;
    repeat (2) begin
      @(negedge Clock);
      chk("late_ack_req", {31'd0, MemReq_Out}, 32'd0);
      chk("late_ack_done", {31'd0, Done_Out}, 32'd0);
    end
    force_ack = 1'b0;
    @(posedge Clock);
    #1;
    ack_delay = 0;
    MemRead_In = 1'b1; Address_In = 32'h20; ByteSel_In = 2'b00;
    exp_txn++;
    repeat (3) @(negedge Clock);
    chk("busy_before_rst", {31'd0, MemReq_Out}, 32'd1);
    Reset = 1'b1;
    MemRead_In = 1'b0; Address_In = '0;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    force_ack = 1'b1;
    repeat (2) begin
      @(negedge Clock);
      chk("rst_busy_req", {31'd0, MemReq_Out}, 32'd0);
      chk("rst_busy_done", {31'd0, Done_Out}, 32'd0);
      chk("rst_busy_stall", {31'd0, Stall_Out}, 32'd0);
    end
    force_ack = 1'b0;
    @(posedge Clock);
    #1;
    access(1, 1, 2'b00, 32'h10, 32'h12345678, 1, 32'hCAFEF00D, 2, 1, 1, 32'h12345678, 4'b1111, 32'h0, 0, 0);
    access(0, 1, 2'b11, 32'h11, 32'h000000A5, 1, 32'h0, 2, 1, 1, 32'hA5A5A5A5, 4'b0010, 32'h0, 0, 0);
    access(1, 0, 2'b00, 32'h14, 32'h0, 1, 32'h0BADF00D, 2, 1, 0, 32'h0, 4'b1111, 32'h0BADF00D, 0, 0);
    repeat (3) @(negedge Clock);
    chk("txn_count", txn, exp_txn);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
